// File: rtl/cache_valid_sequencer.sv
// Purpose : one write port to the per-set valid array, shared by fills, invalidates and a flush walker.
// Latency : one cycle from accepted request to wr_* (fill, invalidate, walker step); flush of NUM_SETS sets takes NUM_SETS+1 cycles uncontended.
// Backpressure: fixed priority fill > invalidate > walker; losers hold and retry; fills are never stalled.
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   fill_en/set     single-cycle fill, writes 1 to fill_set
//   inval_req/set   level request held until inval_ack; writes 0 to inval_set
//   inval_ack       one-cycle pulse coincident with the invalidate write
//   flush_req       pulse starting a full walk; ignored while flush_busy
//   flush_busy      walk in progress
//   flush_done      one-cycle pulse coincident with the write of the last set
//   wr_enable/addr/is_valid  registered valid-array write port
module cache_valid_sequencer #(
    parameter int NUM_SETS        = 32,
    parameter int SET_INDEX_WIDTH = $clog2(NUM_SETS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fill_en,
    input  logic [SET_INDEX_WIDTH-1:0] fill_set,
    input  logic                       inval_req,
    input  logic [SET_INDEX_WIDTH-1:0] inval_set,
    output logic                       inval_ack,
    input  logic                       flush_req,
    output logic                       flush_busy,
    output logic                       flush_done,
    output logic                       wr_enable,
    output logic [SET_INDEX_WIDTH-1:0] wr_addr,
    output logic                       wr_is_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [SET_INDEX_WIDTH-1:0] LAST_SET = SET_INDEX_WIDTH'(NUM_SETS - 1);

    state_t                     state;
    logic [SET_INDEX_WIDTH-1:0] ptr;

    // A request still high during its own ack cycle must not be taken again.
    logic inval_take;
    assign inval_take = inval_req && !inval_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= '0;
            wr_enable   <= 1'b0;
            wr_addr     <= '0;
            wr_is_valid <= 1'b0;
            inval_ack   <= 1'b0;
            flush_busy  <= 1'b0;
            flush_done  <= 1'b0;
        end else begin
            // Strobes default low; wr_addr/wr_is_valid hold when nothing writes.
            wr_enable  <= 1'b0;
            inval_ack  <= 1'b0;
            flush_done <= 1'b0;

            if (fill_en) begin
                wr_enable   <= 1'b1;
                wr_addr     <= fill_set;
                wr_is_valid <= 1'b1;
            end else if (inval_take) begin
                wr_enable   <= 1'b1;
                wr_addr     <= inval_set;
                wr_is_valid <= 1'b0;
                inval_ack   <= 1'b1;
            end else if (state == FLUSH) begin
                wr_enable   <= 1'b1;
                wr_addr     <= ptr;
                wr_is_valid <= 1'b0;
                // NUM_SETS is a power of two, so ptr wraps back to 0 naturally.
                ptr         <= ptr + SET_INDEX_WIDTH'(1);
                if (ptr == LAST_SET) begin
                    state      <= IDLE;
                    flush_busy <= 1'b0;
                    flush_done <= 1'b1;
                end
            end

            // A request arriving while busy is dropped, not queued.
            if (state == IDLE && flush_req) begin
                state      <= FLUSH;
                flush_busy <= 1'b1;
                ptr        <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cache_valid_sequencer.sv
module tb_cache_valid_sequencer;

    localparam int NS = 32;
    localparam int SW = $clog2(NS);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          fill_en = 1'b0;
    logic [SW-1:0] fill_set = '0;
    logic          inval_req = 1'b0;
    logic [SW-1:0] inval_set = '0;
    logic          flush_req = 1'b0;
    logic          inval_ack, flush_busy, flush_done, wr_enable, wr_is_valid;
    logic [SW-1:0] wr_addr;

    cache_valid_sequencer #(.NUM_SETS(NS), .SET_INDEX_WIDTH(SW)) dut (
        .clk        (clk),
        .reset      (reset),
        .fill_en    (fill_en),
        .fill_set   (fill_set),
        .inval_req  (inval_req),
        .inval_set  (inval_set),
        .inval_ack  (inval_ack),
        .flush_req  (flush_req),
        .flush_busy (flush_busy),
        .flush_done (flush_done),
        .wr_enable  (wr_enable),
        .wr_addr    (wr_addr),
        .wr_is_valid(wr_is_valid)
    );

    always #5 clk = ~clk;

    // Expected write: which set, what value, strobes riding with it, and the cycle it must appear.
    typedef struct {
        int addr;
        bit val;
        bit ack;
        bit done;
        int cyc;
    } exp_t;

    exp_t sb[$];        // scoreboard of expected writes
    int   walkq[$];     // sets the flush still has to clear, in order
    bit   m_ack;        // model: ack expected in the next cycle
    bit   ack_prev;     // model: ack happened in the previous cycle
    bit   exp_busy;     // model: flush_busy expected at the next edge
    bit   inv_active;   // requester holds inval_req
    bit   m_arr[NS];
    bit   dut_arr[NS];
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;
    int   last_done_cyc = -1;
    int   nwr5 = 0;
    logic [SW-1:0] last_addr = '0;
    logic          last_val = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk = nchk + 1;
        if (act !== exp) begin
            nerr = nerr + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one look per cycle, just after the active edge.
    task automatic mon();
        exp_t e;
        chk("flush_busy", 32'(flush_busy), 32'(exp_busy));
        if (wr_enable === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'(wr_addr), 32'hffff_ffff);
            end else begin
                e = sb.pop_front();
                chk("wr_cycle", cyc, e.cyc);
                chk("wr_addr", 32'(wr_addr), e.addr);
                chk("wr_is_valid", 32'(wr_is_valid), 32'(e.val));
                chk("inval_ack", 32'(inval_ack), 32'(e.ack));
                chk("flush_done", 32'(flush_done), 32'(e.done));
            end
            dut_arr[wr_addr] = wr_is_valid;
            if (wr_addr == 5 && wr_is_valid == 1'b0) nwr5 = nwr5 + 1;
            if (flush_done === 1'b1) last_done_cyc = cyc;
            last_addr = wr_addr;
            last_val  = wr_is_valid;
        end else begin
            chk("wr_enable_idle", 32'(wr_enable), 0);
            chk("strobes_idle", 32'({inval_ack, flush_done}), 0);
            chk("wr_addr_hold", 32'(wr_addr), 32'(last_addr));
            chk("wr_is_valid_hold", 32'(wr_is_valid), 32'(last_val));
            if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                chk("missing_write_addr", 32'hffff_ffff, e.addr);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset === 1'b1) mon();
        end
    end

    // Reference model step for the cycle whose inputs were just driven.
    task automatic step();
        exp_t e;
        bit   ack_cur  = m_ack;
        bit   busy_cur = (walkq.size() != 0);
        int   s;
        m_ack = 1'b0;
        if (fill_en) begin
            e = '{addr: int'(fill_set), val: 1'b1, ack: 1'b0, done: 1'b0, cyc: cyc + 1};
            sb.push_back(e);
            m_arr[fill_set] = 1'b1;
        end else if (inval_req && !ack_cur) begin
            e = '{addr: int'(inval_set), val: 1'b0, ack: 1'b1, done: 1'b0, cyc: cyc + 1};
            sb.push_back(e);
            m_arr[inval_set] = 1'b0;
            m_ack = 1'b1;
        end else if (busy_cur) begin
            s = walkq.pop_front();
            e = '{addr: s, val: 1'b0, ack: 1'b0, done: (walkq.size() == 0), cyc: cyc + 1};
            sb.push_back(e);
            m_arr[s] = 1'b0;
        end
        if (flush_req && !busy_cur) begin
            for (int i = 0; i < NS; i++) walkq.push_back(i);
        end
        exp_busy = (walkq.size() != 0);
        ack_prev = ack_cur;
    endtask

    task automatic drive_cycle(input bit fe, input logic [SW-1:0] fs, input bit fr,
                               input bit si, input logic [SW-1:0] is);
        bit dropped = 1'b0;
        @(negedge clk);
        // Requester drops the cycle after it saw its ack.
        if (ack_prev && inv_active) begin
            inv_active = 1'b0;
            dropped    = 1'b1;
        end
        if (si && !inv_active && !dropped) begin
            inv_active = 1'b1;
            inval_set  = is;
        end
        inval_req = inv_active;
        fill_en   = fe;
        fill_set  = fs;
        flush_req = fr;
        step();
    endtask

    task automatic idle();
        drive_cycle(1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || walkq.size() != 0 || inv_active) && n < 300) begin
            idle();
            n++;
        end
        if (n >= 300) chk("drain_timeout", 32'(sb.size()), 0);
        idle();
        idle();
    endtask

    task automatic wait_ptr(input int target);
        int n = 0;
        while (walkq.size() != 0 && walkq[0] != target && n < 100) begin
            idle();
            n++;
        end
        chk("walk_reached_ptr", walkq.size() != 0 ? walkq[0] : -1, target);
    endtask

    task automatic clear_model();
        sb.delete();
        walkq.delete();
        m_ack      = 1'b0;
        ack_prev   = 1'b0;
        exp_busy   = 1'b0;
        inv_active = 1'b0;
        last_addr  = '0;
        last_val   = 1'b0;
        for (int i = 0; i < NS; i++) begin
            m_arr[i]   = 1'b0;
            dut_arr[i] = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_enable"}, 32'(wr_enable), 0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
        chk({tag, "_wr_is_valid"}, 32'(wr_is_valid), 0);
        chk({tag, "_inval_ack"}, 32'(inval_ack), 0);
        chk({tag, "_flush_busy"}, 32'(flush_busy), 0);
        chk({tag, "_flush_done"}, 32'(flush_done), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n0;
        bit busy;
        bit fr;
        bit fe;

        clear_model();
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Idle after reset: monitor expects no writes and no busy.
        repeat (10) idle();

        // Uncontended flush.
        drive_cycle(1'b0, '0, 1'b1, 1'b0, '0);
        c0 = cyc;
        drain();
        chk("flush_done_cycle", last_done_cyc - c0, 33);

        // Held invalidate of set 5: single write.
        n0 = nwr5;
        drive_cycle(1'b0, '0, 1'b0, 1'b1, SW'(5));
        drain();
        chk("inval5_single_write", nwr5 - n0, 1);

        // Fill and invalidate to set 7 in the same cycle.
        drive_cycle(1'b1, SW'(7), 1'b0, 1'b1, SW'(7));
        drain();
        chk("fill_inval_set7_final", 32'(dut_arr[7]), 0);

        // Invalidate of set 20 preempts the walker at ptr 10.
        drive_cycle(1'b0, '0, 1'b1, 1'b0, '0);
        c0 = cyc;
        wait_ptr(10);
        drive_cycle(1'b0, '0, 1'b0, 1'b1, SW'(20));
        drain();
        chk("flush_done_cycle_preempted", last_done_cyc - c0, 34);

        // Reset mid-walk once ptr has reached 12.
        drive_cycle(1'b0, '0, 1'b1, 1'b0, '0);
        wait_ptr(12);
        @(posedge clk);
        #3;
        reset     = 1'b0;
        fill_en   = 1'b0;
        inval_req = 1'b0;
        flush_req = 1'b0;
        #1;
        chk_reset_outputs("midflush_reset");
        clear_model();
        last_done_cyc = -1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) idle();
        chk("no_done_after_reset", last_done_cyc, -1);
        drive_cycle(1'b0, '0, 1'b1, 1'b0, '0);
        c0 = cyc;
        drain();
        chk("flush_done_after_reset", last_done_cyc - c0, 33);

        // Random traffic; no fills while a flush is walking.
        repeat (1500) begin
            busy = (walkq.size() != 0);
            fr   = ($urandom_range(49) == 0);
            fe   = !busy && !fr && ($urandom_range(2) == 0);
            drive_cycle(fe, SW'($urandom_range(NS - 1)), fr,
                        ($urandom_range(3) == 0), SW'($urandom_range(NS - 1)));
        end
        drain();

        for (int i = 0; i < NS; i++) chk("array_state", 32'(dut_arr[i]), 32'(m_arr[i]));
        chk("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
